// File: rtl/clock_pkg.sv
// clock_pkg: mode codes, field indices and per-mode field counts shared by the
// front-panel controller, setters and datapath.
package clock_pkg;
    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_TIME  = 2'b01,
        MODE_DATE  = 2'b10,
        MODE_ALARM = 2'b11
    } mode_t;

    localparam logic [1:0] FLD_HOUR = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_SEC  = 2'd2;
    localparam logic [1:0] FLD_DAY  = 2'd0;
    localparam logic [1:0] FLD_MON  = 2'd1;
    localparam logic [1:0] FLD_YEAR = 2'd2;
    localparam logic [1:0] FLD_WDAY = 2'd3;

    localparam int FIELDS_TIME  = 3;
    localparam int FIELDS_DATE  = 4;
    localparam int FIELDS_ALARM = 2;

    function automatic logic [1:0] last_field(input mode_t m);
        return (m == MODE_TIME) ? 2'(FIELDS_TIME - 1) :
               (m == MODE_DATE) ? 2'(FIELDS_DATE - 1) :
               (m == MODE_ALARM) ? 2'(FIELDS_ALARM - 1) : 2'd0;
    endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, counter debounce and one-cycle pulse on
// the rising edge of the debounced level.
module btn_conditioner #(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    logic        sync1_q, sync2_q, level_q, level_d, press_q, press_d, flip;
    logic [19:0] cnt_q, cnt_d;

    always_comb begin
        flip    = (sync2_q != level_q) && (cnt_q == DEBOUNCE_CYC - 20'd1);
        cnt_d   = (sync2_q == level_q || flip) ? '0 : cnt_q + 20'd1;
        level_d = flip ? sync2_q : level_q;
        press_d = flip & sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: front-panel mode sequencer with per-field strobes,
// commit/abort handshakes to the setters and an inactivity timeout.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
    parameter logic [5:0]  TIMEOUT_S    = 6'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode_raw,
    input  logic       btn_a_raw,
    input  logic       btn_b_raw,
    input  logic       btn_c_raw,
    input  logic       ring,
    output logic [1:0] clk_mode,
    output logic [1:0] field_sel,
    output logic       inc_hi,
    output logic       inc_lo,
    output logic       enter_set,
    output logic       commit,
    output logic       abort,
    output logic [1:0] commit_mode,
    output logic       dismiss
);
    logic       p_mode, p_a, p_b, p_c;
    mode_t      mode_q, mode_d, mode_nx;
    logic [1:0] field_q, field_d, cmode_q, cmode_d;
    logic [5:0] to_q, to_d;
    logic       inc_hi_q, inc_hi_d, inc_lo_q, inc_lo_d, enter_q, enter_d;
    logic       commit_q, commit_d, abort_q, abort_d, dismiss_q, dismiss_d;

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (.clk(clk), .rst(rst), .raw(btn_mode_raw), .press(p_mode));
    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_a    (.clk(clk), .rst(rst), .raw(btn_a_raw),    .press(p_a));
    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_b    (.clk(clk), .rst(rst), .raw(btn_b_raw),    .press(p_b));
    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_c    (.clk(clk), .rst(rst), .raw(btn_c_raw),    .press(p_c));

    always_comb begin
        mode_nx   = mode_t'(mode_q + 2'd1);
        mode_d    = mode_q;
        field_d   = field_q;
        cmode_d   = cmode_q;
        to_d      = to_q;
        inc_hi_d  = 1'b0;
        inc_lo_d  = 1'b0;
        enter_d   = 1'b0;
        commit_d  = 1'b0;
        abort_d   = 1'b0;
        dismiss_d = 1'b0;
        if (mode_q == MODE_RUN) begin
            to_d      = '0;
            mode_d    = p_mode ? MODE_TIME : MODE_RUN;
            field_d   = FLD_HOUR;
            enter_d   = p_mode;
            dismiss_d = !p_mode && p_a && ring;
        end else if (p_mode) begin
            mode_d   = mode_nx;
            field_d  = FLD_HOUR;
            cmode_d  = mode_q;
            commit_d = 1'b1;
            enter_d  = mode_nx != MODE_RUN;
            to_d     = '0;
        end else if (p_a || p_b || p_c) begin
            inc_hi_d = p_a;
            inc_lo_d = p_b;
            field_d  = !p_c ? field_q : (field_q == last_field(mode_q)) ? 2'd0 : field_q + 2'd1;
            to_d     = '0;
        end else if (to_q >= TIMEOUT_S) begin
            mode_d  = MODE_RUN;
            field_d = FLD_HOUR;
            abort_d = 1'b1;
            to_d    = '0;
        end else if (tick_1hz) begin
            to_d = (to_q == 6'h3f) ? to_q : to_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_RUN;
            field_q   <= '0;
            cmode_q   <= '0;
            to_q      <= '0;
            inc_hi_q  <= 1'b0;
            inc_lo_q  <= 1'b0;
            enter_q   <= 1'b0;
            commit_q  <= 1'b0;
            abort_q   <= 1'b0;
            dismiss_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            field_q   <= field_d;
            cmode_q   <= cmode_d;
            to_q      <= to_d;
            inc_hi_q  <= inc_hi_d;
            inc_lo_q  <= inc_lo_d;
            enter_q   <= enter_d;
            commit_q  <= commit_d;
            abort_q   <= abort_d;
            dismiss_q <= dismiss_d;
        end
    end

    assign clk_mode    = mode_q;
    assign field_sel   = field_q;
    assign commit_mode = cmode_q;
    assign inc_hi      = inc_hi_q;
    assign inc_lo      = inc_lo_q;
    assign enter_set   = enter_q;
    assign commit      = commit_q;
    assign abort       = abort_q;
    assign dismiss     = dismiss_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed scenarios plus random button/tick traffic checked
// against an abstract mode/field/idle-seconds model.
module tb_clock_mode_ctrl;
    localparam int D = 4;
    localparam int T = 3;
    localparam int LAT = D + 3;
    localparam int HOLD = 12;

    logic       clk = 1'b0, rst = 1'b1, tick_1hz = 1'b0, ring = 1'b0;
    logic       btn_mode_raw = 1'b0, btn_a_raw = 1'b0, btn_b_raw = 1'b0, btn_c_raw = 1'b0;
    logic [1:0] clk_mode, field_sel, commit_mode;
    logic       inc_hi, inc_lo, enter_set, commit, abort, dismiss;

    int checks = 0, failures = 0;
    int m_mode = 0, m_field = 0, m_idle = 0;
    int nfields [4] = '{1, 3, 4, 2};

    clock_mode_ctrl #(.DEBOUNCE_CYC(20'(D)), .TIMEOUT_S(6'(T))) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode_raw(btn_mode_raw), .btn_a_raw(btn_a_raw), .btn_b_raw(btn_b_raw), .btn_c_raw(btn_c_raw),
        .ring(ring), .clk_mode(clk_mode), .field_sel(field_sel), .inc_hi(inc_hi), .inc_lo(inc_lo),
        .enter_set(enter_set), .commit(commit), .abort(abort), .commit_mode(commit_mode), .dismiss(dismiss)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] obs_vec();
        return {clk_mode, field_sel, inc_hi, inc_lo, enter_set, commit, abort, dismiss};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        {btn_mode_raw, btn_a_raw, btn_b_raw, btn_c_raw, tick_1hz} = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 10'd0 || commit_mode !== 2'd0) begin
            failures++;
            $display("FAIL reset: got %b cm=%b want 0", obs_vec(), commit_mode);
        end
        @(negedge clk);
        rst = 1'b0;
        m_mode = 0; m_field = 0; m_idle = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 10'd0) begin
            failures++;
            $display("FAIL reset_release: got %b want 0", obs_vec());
        end
    endtask

    // mask bits: {mode, a, b, c}; all raws move together so pulses coincide
    task automatic press(input logic [3:0] m);
        logic [9:0] pre, post;
        logic       hi, lo, en, co, di;
        int         nm, nf, cm;
        nm = m_mode; nf = m_field; cm = 0;
        {hi, lo, en, co, di} = '0;
        if (m[3]) begin
            nm = (m_mode + 1) % 4;
            co = m_mode != 0;
            cm = m_mode;
            en = nm != 0;
            nf = 0;
            m_idle = 0;
        end else if (m_mode == 0) begin
            di = m[2] & ring;
        end else begin
            hi = m[2];
            lo = m[1];
            if (m[0]) nf = (m_field + 1) % nfields[m_mode];
            m_idle = 0;
        end
        pre  = {2'(m_mode), 2'(m_field), 6'd0};
        post = {2'(nm), 2'(nf), hi, lo, en, co, 1'b0, di};
        @(negedge clk);
        {btn_mode_raw, btn_a_raw, btn_b_raw, btn_c_raw} = m;
        for (int k = 1; k <= HOLD; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_vec() !== (k < LAT ? pre : k == LAT ? post : {post[9:6], 6'd0})) begin
                failures++;
                $display("FAIL press(%b) cyc %0d: got %b want %b", m, k, obs_vec(),
                         k < LAT ? pre : k == LAT ? post : {post[9:6], 6'd0});
            end
            if (k == LAT && co) begin
                checks++;
                if (commit_mode !== 2'(cm)) begin
                    failures++;
                    $display("FAIL commit_mode: got %0d want %0d", commit_mode, cm);
                end
            end
        end
        @(negedge clk);
        {btn_mode_raw, btn_a_raw, btn_b_raw, btn_c_raw} = '0;
        for (int k = 1; k <= HOLD; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_vec() !== {post[9:6], 6'd0}) begin
                failures++;
                $display("FAIL release(%b) cyc %0d: got %b want %b", m, k, obs_vec(), {post[9:6], 6'd0});
            end
        end
        m_mode = nm;
        m_field = nf;
    endtask

    task automatic tick();
        logic [9:0] pre, post;
        logic       ab;
        pre = {2'(m_mode), 2'(m_field), 6'd0};
        @(negedge clk);
        tick_1hz = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== pre) begin
            failures++;
            $display("FAIL tick_edge: got %b want %b", obs_vec(), pre);
        end
        @(negedge clk);
        tick_1hz = 1'b0;
        if (m_mode != 0) m_idle++;
        ab = m_idle >= T;
        if (ab) begin
            m_mode = 0; m_field = 0; m_idle = 0;
        end
        post = {2'(m_mode), 2'(m_field), 4'd0, ab, 1'b0};
        @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== post) begin
            failures++;
            $display("FAIL tick_after: got %b want %b", obs_vec(), post);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== {post[9:6], 6'd0}) begin
            failures++;
            $display("FAIL tick_settle: got %b want %b", obs_vec(), {post[9:6], 6'd0});
        end
    endtask

    task automatic test_bounce();
        test_reset();
        ring = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            btn_a_raw = ~btn_a_raw;
            repeat (2) begin
                @(posedge clk);
                #1;
                checks++;
                if (obs_vec() !== 10'd0) begin
                    failures++;
                    $display("FAIL bounce_quiet: got %b want 0", obs_vec());
                end
            end
        end
        for (int k = 3; k <= 20; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (dismiss !== (k == LAT)) begin
                failures++;
                $display("FAIL bounce_pulse cyc %0d: dismiss=%b want %b", k, dismiss, k == LAT);
            end
        end
        @(negedge clk);
        btn_a_raw = 1'b0;
        ring = 1'b0;
        repeat (HOLD) @(posedge clk);
    endtask

    task automatic test_sequence();
        test_reset();
        repeat (4) press(4'b1000);
        checks++;
        if (clk_mode !== 2'b00) begin
            failures++;
            $display("FAIL sequence_end: clk_mode=%b want 00", clk_mode);
        end
    endtask

    task automatic test_field_wrap();
        test_reset();
        press(4'b1000);
        press(4'b1000);
        repeat (5) press(4'b0001);
        press(4'b1000);
        repeat (2) press(4'b0001);
    endtask

    task automatic test_timeout();
        test_reset();
        press(4'b1000);
        repeat (T) tick();
        press(4'b1000);
        repeat (2) tick();
        press(4'b0010);
        repeat (T) tick();
        checks++;
        if (clk_mode !== 2'b00) begin
            failures++;
            $display("FAIL timeout_mode: clk_mode=%b want 00", clk_mode);
        end
    endtask

    task automatic test_priority();
        test_reset();
        press(4'b1000);
        press(4'b1100);
        press(4'b0110);
        press(4'b0101);
    endtask

    task automatic test_dismiss_reset();
        test_reset();
        ring = 1'b1;
        press(4'b0100);
        ring = 1'b0;
        press(4'b0100);
        press(4'b1000);
        press(4'b1000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_vec() !== 10'd0) begin
                failures++;
                $display("FAIL reset_mid cyc %0d: got %b want 0", k, obs_vec());
            end
        end
        @(negedge clk);
        rst = 1'b0;
        m_mode = 0; m_field = 0; m_idle = 0;
        @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 10'd0) begin
            failures++;
            $display("FAIL reset_mid_after: got %b want 0", obs_vec());
        end
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0, 1: press(4'($urandom_range(1, 7)));
                2:    press(4'($urandom_range(1, 15)));
                3:    tick();
                default: begin
                    @(negedge clk);
                    ring = 1'($urandom_range(0, 1));
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_sequence();
        test_field_wrap();
        test_timeout();
        test_priority();
        test_dismiss_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
